cpu_sequencer: RTL

//  Multi-cycle control FSM for the 8-bit CPU. Steps each instruction through five phases:

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/cpu_sequencer.sv | 97 +++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: sequencer state encoding and instruction field layout.
// The decode unit uses the same field positions.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_READ   = 3'd3,
    ST_EXEC   = 3'd4,
    ST_WRITE  = 3'd5,
    ST_PAUSE  = 3'd6,
    ST_DONE   = 3'd7
  } seq_state_t;

  localparam int OP_MSB   = 7;
  localparam int OP_LSB   = 6;
  localparam int SRC1_MSB = 5;
  localparam int SRC1_LSB = 4;
  localparam int SRC2_MSB = 3;
  localparam int SRC2_LSB = 2;
  localparam int DEST_MSB = 1;
  localparam int DEST_LSB = 0;

  // States in which an instruction is in flight or suspended.
  function automatic logic is_busy_state(input seq_state_t s);
    return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_READ) ||
           (s == ST_EXEC)  || (s == ST_WRITE)  || (s == ST_PAUSE);
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Five-phase instruction sequencer for the 8-bit CPU: drives one enable per phase,
// owns the program counter and counts retired instructions.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W     = 4,
  parameter int PROG_LEN = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            step_mode,
  input  logic            step,
  output logic [PC_W-1:0] pc,
  output logic            fetch_en,
  output logic            decode_en,
  output logic            read_en,
  output logic            exec_en,
  output logic            write_en,
  output logic            busy,
  output logic            done,
  output logic [7:0]      retired_cnt
);

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

  seq_state_t state;
  seq_state_t next_state;
  logic       abort_now;
  logic       launch;
  logic       retire;

  assign abort_now = abort && (state != ST_IDLE);
  assign launch    = start && ((state == ST_IDLE) || (state == ST_DONE)) && !abort_now;
  assign retire    = (state == ST_WRITE) && !abort_now;

  always_comb begin
    next_state = state;
    if (abort_now) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start) next_state = ST_FETCH;
        ST_FETCH:  next_state = ST_DECODE;
        ST_DECODE: next_state = ST_READ;
        ST_READ:   next_state = ST_EXEC;
        ST_EXEC:   next_state = ST_WRITE;
        ST_WRITE: begin
          if (pc == LAST_PC)  next_state = ST_DONE;
          else if (step_mode) next_state = ST_PAUSE;
          else                next_state = ST_FETCH;
        end
        ST_PAUSE:  if (step || !step_mode) next_state = ST_FETCH;
        ST_DONE:   if (start) next_state = ST_FETCH;
        default:   next_state = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from next_state so they are registered yet line up with the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      fetch_en  <= 1'b0;
      decode_en <= 1'b0;
      read_en   <= 1'b0;
      exec_en   <= 1'b0;
      write_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= next_state;
      fetch_en  <= (next_state == ST_FETCH);
      decode_en <= (next_state == ST_DECODE);
      read_en   <= (next_state == ST_READ);
      exec_en   <= (next_state == ST_EXEC);
      write_en  <= (next_state == ST_WRITE);
      busy      <= is_busy_state(next_state);
      done      <= (next_state == ST_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= '0;
      retired_cnt <= '0;
    end else if (launch) begin
      pc          <= '0;
      retired_cnt <= '0;
    end else if (retire) begin
      if (retired_cnt != 8'hFF) retired_cnt <= retired_cnt + 8'd1;
      if (pc != LAST_PC)        pc          <= pc + PC_W'(1);
    end
  end

endmodule
